// File: rtl/can_tx_serializer.sv
// CAN 2.0A classic-frame transmit serializer.
// Sends one frame per accepted START, one bit per BIT_TICK, with bit stuffing
// from SOF through CRC and a strobed bit stream toward an external CRC unit.
module can_tx_serializer (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BIT_TICK,
   input  logic        START,
   input  logic [10:0] ID,
   input  logic        RTR,
   input  logic [3:0]  DLC,
   input  logic [63:0] DATA,
   input  logic [14:0] CRC_IN,
   output logic        CRC_CLEAR,
   output logic        CRC_BIT,
   output logic        CRC_STRB,
   output logic        TX_BIT,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic [3:0] {
      S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
      S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
   } state_t;

   state_t      state;
   logic [10:0] id_q;
   logic        rtr_q;
   logic [3:0]  dlc_q;
   logic [63:0] data_q;
   logic [14:0] crc_q;
   logic [6:0]  bit_cnt;
   logic [2:0]  run_cnt;
   logic        last_bit;

   logic [3:0]  nbytes;
   logic [6:0]  data_last;
   logic [11:0] arb;
   logic [5:0]  ctrl;
   logic        field_bit;
   logic        stuff_zone;
   logic        crc_zone;
   logic        stuff_now;

   // Field bit for the current state/counter, plus stuffing and CRC-feed qualifiers.
   // run_cnt can only sit at 5 in CRC_DEL when a stuff bit is owed after the last CRC bit.
   always_comb begin
      nbytes     = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);
      data_last  = {nbytes, 3'b000} - 7'd1;
      arb        = {id_q, rtr_q};
      ctrl       = {2'b00, dlc_q};
      field_bit  = 1'b1;
      case (state)
         S_SOF:  field_bit = 1'b0;
         S_ARB:  field_bit = arb[4'd11 - bit_cnt[3:0]];
         S_CTRL: field_bit = ctrl[3'd5 - bit_cnt[2:0]];
         S_DATA: field_bit = data_q[6'd63 - bit_cnt[5:0]];
         S_CRC:  field_bit = (bit_cnt == 7'd0) ? CRC_IN[14] : crc_q[4'd14 - bit_cnt[3:0]];
         default: field_bit = 1'b1;
      endcase
      stuff_zone = (state == S_SOF) || (state == S_ARB) || (state == S_CTRL) ||
                   (state == S_DATA) || (state == S_CRC);
      crc_zone   = (state == S_SOF) || (state == S_ARB) || (state == S_CTRL) ||
                   (state == S_DATA);
      stuff_now  = (run_cnt == 3'd5) && (stuff_zone || (state == S_CRC_DEL));
   end

   // Frame sequencer: acceptance, per-tick bit emission, stuffing and state advance.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         TX_BIT    <= 1'b1;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         CRC_STRB  <= 1'b0;
         CRC_CLEAR <= 1'b0;
         CRC_BIT   <= 1'b0;
         bit_cnt   <= 7'd0;
         run_cnt   <= 3'd0;
         last_bit  <= 1'b1;
         id_q      <= 11'd0;
         rtr_q     <= 1'b0;
         dlc_q     <= 4'd0;
         data_q    <= 64'd0;
         crc_q     <= 15'd0;
      end else begin
         CRC_CLEAR <= 1'b0;
         CRC_STRB  <= 1'b0;
         DONE      <= 1'b0;
         if (state == S_IDLE) begin
            // A tick coincident with START is consumed here, so SOF waits for the next one.
            if (START) begin
               id_q      <= ID;
               rtr_q     <= RTR;
               dlc_q     <= DLC;
               data_q    <= DATA;
               CRC_CLEAR <= 1'b1;
               BUSY      <= 1'b1;
               bit_cnt   <= 7'd0;
               run_cnt   <= 3'd0;
               state     <= S_SOF;
            end
         end else if (BIT_TICK) begin
            if (stuff_now) begin
               TX_BIT   <= ~last_bit;
               last_bit <= ~last_bit;
               run_cnt  <= 3'd1;
            end else begin
               TX_BIT  <= field_bit;
               bit_cnt <= bit_cnt + 7'd1;
               if (stuff_zone) begin
                  run_cnt  <= (run_cnt != 3'd0 && field_bit == last_bit) ? run_cnt + 3'd1 : 3'd1;
                  last_bit <= field_bit;
               end else begin
                  run_cnt <= 3'd0;
               end
               if (crc_zone) begin
                  CRC_STRB <= 1'b1;
                  CRC_BIT  <= field_bit;
               end
               if (state == S_CRC && bit_cnt == 7'd0)
                  crc_q <= CRC_IN;
               case (state)
                  S_SOF: begin state <= S_ARB; bit_cnt <= 7'd0; end
                  S_ARB: if (bit_cnt == 7'd11) begin state <= S_CTRL; bit_cnt <= 7'd0; end
                  S_CTRL: if (bit_cnt == 7'd5) begin
                     state   <= (nbytes == 4'd0) ? S_CRC : S_DATA;
                     bit_cnt <= 7'd0;
                  end
                  S_DATA: if (bit_cnt == data_last) begin state <= S_CRC; bit_cnt <= 7'd0; end
                  S_CRC: if (bit_cnt == 7'd14) begin state <= S_CRC_DEL; bit_cnt <= 7'd0; end
                  S_CRC_DEL: begin state <= S_ACK; bit_cnt <= 7'd0; end
                  S_ACK: begin state <= S_ACK_DEL; bit_cnt <= 7'd0; end
                  S_ACK_DEL: begin state <= S_EOF; bit_cnt <= 7'd0; end
                  S_EOF: if (bit_cnt == 7'd6) begin state <= S_IFS; bit_cnt <= 7'd0; end
                  S_IFS: if (bit_cnt == 7'd3) begin
                     // Fourth tick in IFS closes the third IFS bit time.
                     state   <= S_IDLE;
                     bit_cnt <= 7'd0;
                     BUSY    <= 1'b0;
                     DONE    <= 1'b1;
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_can_tx_serializer.sv
// Bench for can_tx_serializer: scoreboard of expected CRC-feed bits and
// destuffed line bits, with a CAN CRC-15 unit model answering CRC_IN.
module tb_can_tx_serializer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        BIT_TICK = 1'b0;
   logic        START = 1'b0;
   logic [10:0] ID = '0;
   logic        RTR = 1'b0;
   logic [3:0]  DLC = '0;
   logic [63:0] DATA = '0;
   logic [14:0] CRC_IN;
   logic        CRC_CLEAR, CRC_BIT, CRC_STRB, TX_BIT, BUSY, DONE;

   can_tx_serializer dut (
      .CLK(CLK), .RST(RST), .BIT_TICK(BIT_TICK), .START(START),
      .ID(ID), .RTR(RTR), .DLC(DLC), .DATA(DATA), .CRC_IN(CRC_IN),
      .CRC_CLEAR(CRC_CLEAR), .CRC_BIT(CRC_BIT), .CRC_STRB(CRC_STRB),
      .TX_BIT(TX_BIT), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int tcnt = 0;
   int done_cnt = 0;
   int strb_cnt = 0;

   logic exp_tx[$];
   logic exp_crc[$];
   int   se_q[$];
   logic raw_q[$];

   // Bit-time ticks every 4 clocks, driven mid-cycle.
   always @(posedge CLK) begin
      #2;
      tcnt++;
      BIT_TICK = (tcnt % 4 == 0);
   end

   // CAN CRC-15 unit model.
   logic [14:0] crc_reg = '0;
   assign CRC_IN = crc_reg;
   always @(posedge CLK) begin
      if (CRC_CLEAR) crc_reg <= '0;
      else if (CRC_STRB)
         crc_reg <= {crc_reg[13:0], 1'b0} ^ ((CRC_BIT ^ crc_reg[14]) ? 15'h4599 : 15'h0);
   end

   // Monitor: destuff line bits, score CRC feed, check TX_BIT stability.
   logic m_tk, m_bz, m_rs, prev_tx, m_last, e;
   logic m_in_frame = 1'b0;
   int   m_cnt = 0, m_run = 0, m_se = 0;
   always @(posedge CLK) begin
      m_tk = BIT_TICK; m_bz = BUSY; m_rs = RST;
      #1;
      if (!m_rs) begin
         checks++;
         if (!m_tk && TX_BIT !== prev_tx) begin
            errors++; $display("FAIL tx_stable got=%b exp=%b t=%0t", TX_BIT, prev_tx, $time);
         end
         if (CRC_STRB === 1'b1) begin
            strb_cnt++;
            checks++;
            if (!m_tk) begin errors++; $display("FAIL strb_timing got=strobe exp=after_tick t=%0t", $time); end
            checks++;
            if (exp_crc.size() == 0) begin
               errors++; $display("FAIL crc_bit got=extra_strobe exp=none t=%0t", $time);
            end else begin
               e = exp_crc.pop_front();
               if (CRC_BIT !== e) begin errors++; $display("FAIL crc_bit got=%b exp=%b t=%0t", CRC_BIT, e, $time); end
            end
         end
         if (m_tk && m_bz && DONE !== 1'b1) begin
            raw_q.push_back(TX_BIT);
            if (!m_in_frame) begin
               m_in_frame = 1'b1; m_cnt = 0; m_run = 0;
               m_se = (se_q.size() != 0) ? se_q.pop_front() : 0;
            end
            checks++;
            if (m_run == 5 && m_cnt <= m_se) begin
               if (TX_BIT !== ~m_last) begin
                  errors++; $display("FAIL stuff_bit idx=%0d got=%b exp=%b", m_cnt, TX_BIT, ~m_last);
               end
               m_last = TX_BIT; m_run = 1;
            end else begin
               if (exp_tx.size() == 0) begin
                  errors++; $display("FAIL tx_bit idx=%0d got=extra_bit exp=none", m_cnt);
               end else begin
                  e = exp_tx.pop_front();
                  if (TX_BIT !== e) begin errors++; $display("FAIL tx_bit idx=%0d got=%b exp=%b", m_cnt, TX_BIT, e); end
               end
               m_run = (m_run != 0 && TX_BIT === m_last) ? m_run + 1 : 1;
               m_last = TX_BIT;
               m_cnt++;
            end
         end
         if (DONE === 1'b1) begin done_cnt++; m_in_frame = 1'b0; end
      end else begin
         m_in_frame = 1'b0;
      end
      prev_tx = TX_BIT;
   end

   // Reference frame builder: pushes CRC-feed bits and unstuffed line bits.
   task automatic push_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, output int nstrb);
      logic q[$];
      logic [14:0] c;
      int n;
      n = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
      q.push_back(1'b0);
      for (int i = 10; i >= 0; i--) q.push_back(id[i]);
      q.push_back(rtr); q.push_back(1'b0); q.push_back(1'b0);
      for (int i = 3; i >= 0; i--) q.push_back(dlc[i]);
      for (int i = 0; i < 8 * n; i++) q.push_back(data[63 - i]);
      c = '0;
      foreach (q[i]) begin
         c = {c[13:0], 1'b0} ^ ((q[i] ^ c[14]) ? 15'h4599 : 15'h0);
         exp_crc.push_back(q[i]);
      end
      for (int i = 14; i >= 0; i--) q.push_back(c[i]);
      repeat (13) q.push_back(1'b1);
      foreach (q[i]) exp_tx.push_back(q[i]);
      se_q.push_back(34 + 8 * n);
      nstrb = 19 + 8 * n;
   endtask

   task automatic start_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data);
      @(posedge CLK); #2;
      ID = id; RTR = rtr; DLC = dlc; DATA = data; START = 1'b1;
      @(posedge CLK); #2;
      START = 1'b0;
   endtask

   task automatic wait_done(input int d0, output bit ok);
      int k = 0;
      while (done_cnt == d0 && k < 2000) begin @(posedge CLK); k++; end
      ok = (done_cnt != d0);
      @(posedge CLK);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if ({TX_BIT, BUSY, DONE, CRC_STRB, CRC_CLEAR, CRC_BIT} !== 6'b100000) begin
         errors++; $display("FAIL reset_outputs got=%b exp=100000", {TX_BIT, BUSY, DONE, CRC_STRB, CRC_CLEAR, CRC_BIT});
      end
      #1 RST = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      checks++;
      if (BUSY !== 1'b0 || TX_BIT !== 1'b1) begin
         errors++; $display("FAIL idle_after_reset got=%b%b exp=01", BUSY, TX_BIT);
      end
   endtask

   task automatic test_basic();
      int ns, d0, s0; bit ok;
      push_frame(11'h123, 1'b0, 4'd4, {32'hDEADBEEF, 32'h0}, ns);
      d0 = done_cnt; s0 = strb_cnt;
      @(posedge CLK); #2;
      ID = 11'h123; RTR = 1'b0; DLC = 4'd4; DATA = {32'hDEADBEEF, 32'h0}; START = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if (CRC_CLEAR !== 1'b1 || BUSY !== 1'b1) begin
         errors++; $display("FAIL accept got=clr%b busy%b exp=clr1 busy1", CRC_CLEAR, BUSY);
      end
      #1 START = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (CRC_CLEAR !== 1'b0) begin errors++; $display("FAIL clear_pulse got=%b exp=0", CRC_CLEAR); end
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", done_cnt - d0); end
      checks++; if (strb_cnt - s0 != 51) begin errors++; $display("FAIL basic_strb got=%0d exp=51", strb_cnt - s0); end
      checks++; if (ns != 51) begin errors++; $display("FAIL basic_model got=%0d exp=51", ns); end
      checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL basic_left got=%0d exp=0", exp_tx.size()); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", BUSY); end
   endtask

   task automatic test_stuff_zero();
      int ns, d0, s0; bit ok;
      logic [5:0] head;
      push_frame(11'h000, 1'b0, 4'd0, 64'h0, ns);
      d0 = done_cnt; s0 = strb_cnt; raw_q.delete();
      start_frame(11'h000, 1'b0, 4'd0, 64'h0);
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got=no_done exp=done"); end
      head = '1;
      for (int i = 0; i < 6 && i < raw_q.size(); i++) head[5 - i] = raw_q[i];
      checks++; if (head !== 6'b000001) begin errors++; $display("FAIL zero_head got=%b exp=000001", head); end
      checks++; if (strb_cnt - s0 != 19) begin errors++; $display("FAIL zero_strb got=%0d exp=19", strb_cnt - s0); end
      checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL zero_left got=%0d exp=0", exp_tx.size()); end
   endtask

   task automatic test_rtr();
      int ns, d0, s0; bit ok;
      push_frame(11'h5A5, 1'b1, 4'd4, 64'hFFFF_FFFF_0000_0000, ns);
      d0 = done_cnt; s0 = strb_cnt;
      start_frame(11'h5A5, 1'b1, 4'd4, 64'hFFFF_FFFF_0000_0000);
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rtr_timeout got=no_done exp=done"); end
      checks++; if (strb_cnt - s0 != 19) begin errors++; $display("FAIL rtr_strb got=%0d exp=19", strb_cnt - s0); end
      checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL rtr_left got=%0d exp=0", exp_tx.size()); end
   endtask

   task automatic test_dlc15();
      int ns, d0, s0; bit ok;
      push_frame(11'h7F0, 1'b0, 4'd15, 64'h0123456789ABCDEF, ns);
      d0 = done_cnt; s0 = strb_cnt;
      start_frame(11'h7F0, 1'b0, 4'd15, 64'h0123456789ABCDEF);
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dlc15_timeout got=no_done exp=done"); end
      checks++; if (strb_cnt - s0 != 83) begin errors++; $display("FAIL dlc15_strb got=%0d exp=83", strb_cnt - s0); end
      checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL dlc15_left got=%0d exp=0", exp_tx.size()); end
   endtask

   task automatic test_mid_reset();
      int ns, d0, s0, k; bit ok;
      push_frame(11'h555, 1'b0, 4'd8, 64'hA5A5_0F0F_3C3C_FF00, ns);
      d0 = done_cnt; s0 = strb_cnt;
      start_frame(11'h555, 1'b0, 4'd8, 64'hA5A5_0F0F_3C3C_FF00);
      k = 0;
      while (strb_cnt - s0 < 25 && k < 2000) begin @(posedge CLK); k++; end
      checks++; if (strb_cnt - s0 < 25) begin errors++; $display("FAIL mrst_reach got=%0d exp=25", strb_cnt - s0); end
      @(posedge CLK); #2 RST = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if (TX_BIT !== 1'b1 || BUSY !== 1'b0 || CRC_STRB !== 1'b0) begin
         errors++; $display("FAIL mrst_out got=%b%b%b exp=100", TX_BIT, BUSY, CRC_STRB);
      end
      #1;
      exp_tx.delete(); exp_crc.delete(); se_q.delete();
      RST = 1'b0;
      repeat (60) @(posedge CLK);
      #1;
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL mrst_done got=%0d exp=%0d", done_cnt, d0); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b exp=0", BUSY); end
      push_frame(11'h555, 1'b0, 4'd8, 64'hA5A5_0F0F_3C3C_FF00, ns);
      s0 = strb_cnt;
      start_frame(11'h555, 1'b0, 4'd8, 64'hA5A5_0F0F_3C3C_FF00);
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mrst_timeout got=no_done exp=done"); end
      checks++; if (strb_cnt - s0 != 83) begin errors++; $display("FAIL mrst_strb got=%0d exp=83", strb_cnt - s0); end
      checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL mrst_left got=%0d exp=0", exp_tx.size()); end
   endtask

   task automatic test_start_held();
      int na, nb, d0, s0, k; bit ok;
      push_frame(11'h0F3, 1'b0, 4'd2, 64'hC3A5_0000_0000_0000, na);
      push_frame(11'h70C, 1'b0, 4'd1, 64'h8100_0000_0000_0000, nb);
      d0 = done_cnt; s0 = strb_cnt;
      @(posedge CLK); #2;
      ID = 11'h0F3; RTR = 1'b0; DLC = 4'd2; DATA = 64'hC3A5_0000_0000_0000; START = 1'b1;
      k = 0;
      while (BUSY !== 1'b1 && k < 20) begin @(posedge CLK); k++; end
      #2;
      ID = 11'h70C; DLC = 4'd1; DATA = 64'h8100_0000_0000_0000;
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL held_timeout1 got=no_done exp=done"); end
      #1;
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL held_restart got=%b exp=1", BUSY); end
      #1 START = 1'b0;
      wait_done(d0 + 1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL held_timeout2 got=no_done exp=done"); end
      checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL held_done got=%0d exp=2", done_cnt - d0); end
      checks++; if (strb_cnt - s0 != na + nb) begin errors++; $display("FAIL held_strb got=%0d exp=%0d", strb_cnt - s0, na + nb); end
      checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL held_left got=%0d exp=0", exp_tx.size()); end
   endtask

   task automatic test_start_coincident();
      int ns, d0; bit ok;
      push_frame(11'h2AA, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, ns);
      d0 = done_cnt;
      do @(posedge CLK); while (tcnt % 4 != 3);
      #2;
      ID = 11'h2AA; RTR = 1'b0; DLC = 4'd1; DATA = 64'h3C00_0000_0000_0000; START = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if (TX_BIT !== 1'b1 || BUSY !== 1'b1) begin
         errors++; $display("FAIL coinc_sof got=tx%b busy%b exp=tx1 busy1", TX_BIT, BUSY);
      end
      #1 START = 1'b0;
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL coinc_timeout got=no_done exp=done"); end
      checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL coinc_left got=%0d exp=0", exp_tx.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stuff_zero();
      test_rtr();
      test_dlc15();
      test_mid_reset();
      test_start_held();
      test_start_coincident();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
